bcd_ex3_serial_codec: RTL and testbench

//  Multi-digit, digit-serial, bidirectional BCD <-> Excess-3 code converter with valid/ready handshakes.
//  - Accepts a packed word of DIGITS nibbles and converts one digit per clock, least significant digit first.
//  - Flags any digit that is not a legal code word.
//  - Sits between the BCD arithmetic/display datapath and any Excess-3 consumer.
//  - Replaces the single-digit combinational translator wherever words are wider than one digit.

---
 rtl/bcd_ex3_pkg.sv | 21 ++
 rtl/bcd_ex3_serial_codec_if.sv | 30 +++
 rtl/bcd_ex3_digit.sv | 28 ++
 rtl/bcd_ex3_serial_codec.sv | 116 +++++++++++
 tb/tb_bcd_ex3_serial_codec.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_ex3_pkg.sv
// Shared definitions for the BCD <-> Excess-3 digit-serial codec.
//   - mode encodings for the in_mode input
//   - code-range constants used by the per-digit translator
//   - the codec FSM state type (also exposed on the debug port)
package bcd_ex3_pkg;

  localparam logic       MODE_BCD2EX3 = 1'b0;
  localparam logic       MODE_EX32BCD = 1'b1;

  localparam logic [3:0] EX3_OFFSET   = 4'd3;
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] EX3_MIN      = 4'd3;
  localparam logic [3:0] EX3_MAX      = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_ex3_serial_codec_if.sv
// Handshake bundle for bcd_ex3_serial_codec.
// Handshake rule for both channels: a transfer happens on the rising clk
// edge where valid and ready are both 1. The codec raises out_valid and
// holds out_data/out_err_mask/out_err stable until that transfer. It
// accepts input only while in_ready is 1.
//   master : upstream producer / downstream consumer side (drives in_*, out_ready)
//   slave  : the codec itself
interface bcd_ex3_serial_codec_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_data;
  logic                  in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_data;
  logic [DIGITS-1:0]     out_err_mask;
  logic                  out_err;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err_mask, out_err
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err_mask, out_err
  );
endinterface

// File: rtl/bcd_ex3_digit.sv
// Single-digit BCD <-> Excess-3 translator (purely combinational).
// Ports:
//   digit : 4-bit input code
//   mode  : MODE_BCD2EX3 or MODE_EX32BCD
//   code  : translated digit, 4'h0 when the input is illegal
//   err   : 1 when the input digit is not a legal code word for the mode
module bcd_ex3_digit
  import bcd_ex3_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       mode,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = 4'h0;
    err  = 1'b0;
    if (mode == MODE_BCD2EX3) begin
      if (digit <= BCD_MAX) code = digit + EX3_OFFSET;
      else                  err  = 1'b1;
    end else begin
      if ((digit >= EX3_MIN) && (digit <= EX3_MAX)) code = digit - EX3_OFFSET;
      else                                          err  = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_ex3_serial_codec.sv
// Digit-serial BCD <-> Excess-3 word converter.
// A word is captured in IDLE, converted one digit per clock (LSD first)
// in CONV through a single shared bcd_ex3_digit, then presented in HOLD
// until the consumer takes it. Words never overlap.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of bcd_ex3_serial_codec_if (in_* / out_* channels)
//   dbg_state  : current FSM state, for observation only
module bcd_ex3_serial_codec
  import bcd_ex3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bcd_ex3_serial_codec_if.slave         bus,
  output state_t                        dbg_state
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [4*DIGITS-1:0]  cap_data_q;
  logic                 cap_mode_q;
  logic [4*DIGITS-1:0]  res_q;
  logic [DIGITS-1:0]    mask_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [3:0]           cur_digit;
  logic [3:0]           cur_code;
  logic                 cur_err;

  // Select the digit addressed by idx from the captured word.
  always_comb begin
    cur_digit = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) cur_digit = cap_data_q[4*k +: 4];
    end
  end

  bcd_ex3_digit u_digit (
    .digit (cur_digit),
    .mode  (cap_mode_q),
    .code  (cur_code),
    .err   (cur_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cap_data_q  <= '0;
      cap_mode_q  <= MODE_BCD2EX3;
      res_q       <= '0;
      mask_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready comes up one edge after reset release and stays
          // high for as long as the block waits here.
          if (bus.in_valid && in_ready_q) begin
            cap_data_q <= bus.in_data;
            cap_mode_q <= bus.in_mode;
            idx_q      <= '0;
            // Clear results so unconverted digits read 0 until HOLD.
            res_q      <= '0;
            mask_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CONV;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CONV: begin
          for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              res_q[4*k +: 4] <= cur_code;
              mask_q[k]       <= cur_err;
            end
          end
          if (idx_q == IDX_LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = res_q;
  assign bus.out_err_mask = mask_q;
  assign bus.out_err      = |mask_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_bcd_ex3_serial_codec.sv
// Bench for bcd_ex3_serial_codec: a DIGITS=4 instance exercised with
// directed and random words, and a DIGITS=1 instance for the single-digit case.
module tb_bcd_ex3_serial_codec;
  import bcd_ex3_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_ex3_serial_codec_if #(.DIGITS(4)) if4 ();
  bcd_ex3_serial_codec_if #(.DIGITS(1)) if1 ();
  state_t dbg4, dbg1;

  bcd_ex3_serial_codec #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4), .dbg_state(dbg4)
  );
  bcd_ex3_serial_codec #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .dbg_state(dbg1)
  );

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];   // {mask, data} expected for random words

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each digit translated independently with integer arithmetic.
  function automatic void ref_model(input logic [15:0] data, input logic mode,
                                    output logic [15:0] res, output logic [3:0] mask);
    int d, r;
    res = 16'h0;
    mask = 4'h0;
    for (int k = 0; k < 4; k++) begin
      d = int'((data >> (4 * k)) & 16'hF);
      r = 0;
      if (mode == 1'b0) begin
        if (d <= 9) r = d + 3; else mask[k] = 1'b1;
      end else begin
        if (d >= 3 && d <= 12) r = d - 3; else mask[k] = 1'b1;
      end
      res = res | 16'(r << (4 * k));
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Offer a word, wait for the accept edge, then scramble the inputs so a
  // late change would corrupt the result if it were (wrongly) sampled.
  task automatic send4(input logic [15:0] data, input logic mode, input string tag);
    int n = 0;
    while (!if4.in_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, " in_ready"}, 64'(if4.in_ready), 64'd1);
    if4.in_valid = 1'b1;
    if4.in_data  = data;
    if4.in_mode  = mode;
    @(posedge clk);
    @(negedge clk);
    if4.in_valid = 1'b0;
    if4.in_data  = 16'($urandom);
    if4.in_mode  = ~mode;
  endtask

  // Count cycles from the accept edge until out_valid is seen.
  task automatic wait_out4(input string tag, output int lat);
    lat = 0;
    while (!if4.out_valid && lat < 30) begin @(negedge clk); lat++; end
    chk({tag, " out_valid"}, 64'(if4.out_valid), 64'd1);
  endtask

  task automatic take4(input string tag);
    if4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if4.out_ready = 1'b0;
    chk({tag, " drop out_valid"}, 64'(if4.out_valid), 64'd0);
    chk({tag, " in_ready back"}, 64'(if4.in_ready), 64'd1);
  endtask

  task automatic run4(input logic [15:0] data, input logic mode,
                      input logic [15:0] exp_data, input logic [3:0] exp_mask,
                      input string tag);
    int lat;
    send4(data, mode, tag);
    wait_out4(tag, lat);
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " data"}, 64'(if4.out_data), 64'(exp_data));
    chk({tag, " mask"}, 64'(if4.out_err_mask), 64'(exp_mask));
    chk({tag, " err"}, 64'(if4.out_err), 64'(|exp_mask));
    take4(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [15:0] held_data, rd, rdata, rres;
    logic [3:0] held_mask, rmask;
    logic rmode;
    logic [19:0] exp;

    if4.in_valid = 1'b0; if4.in_data = '0; if4.in_mode = 1'b0; if4.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_mode = 1'b0; if1.out_ready = 1'b0;

    // 1. reset values and in_ready rising one edge after release
    repeat (3) @(negedge clk);
    chk("rst in_ready", 64'(if4.in_ready), 64'd0);
    chk("rst out_valid", 64'(if4.out_valid), 64'd0);
    chk("rst out_data", 64'(if4.out_data), 64'd0);
    chk("rst out_err", 64'(if4.out_err), 64'd0);
    chk("rst mask", 64'(if4.out_err_mask), 64'd0);
    chk("rst state", 64'(dbg4), 64'(IDLE));
    rst_n = 1'b1;
    #1;
    chk("rel in_ready before edge", 64'(if4.in_ready), 64'd0);
    @(negedge clk);
    chk("rel in_ready after edge", 64'(if4.in_ready), 64'd1);
    chk("rel in_ready d1", 64'(if1.in_ready), 64'd1);

    // 2-5. directed words
    run4(16'h1928, MODE_BCD2EX3, 16'h4C5B, 4'b0000, "bcd2ex3");
    run4(16'h4C5B, MODE_EX32BCD, 16'h1928, 4'b0000, "ex32bcd");
    run4(16'h0D23, MODE_EX32BCD, 16'h0000, 4'b1110, "ex3 illegal");
    run4(16'hA0F9, MODE_BCD2EX3, 16'h030C, 4'b1010, "bcd illegal");

    // 6. backpressure: outputs hold, extra in_valid pulses ignored
    send4(16'h0457, MODE_BCD2EX3, "bp");
    wait_out4("bp", lat);
    held_data = if4.out_data;
    held_mask = if4.out_err_mask;
    chk("bp data", 64'(held_data), 64'h378A);
    chk("bp mask", 64'(held_mask), 64'h0);
    for (int i = 0; i < 5; i++) begin
      if4.in_valid = i[0];
      if4.in_data  = 16'($urandom);
      @(negedge clk);
      chk("bp hold data", 64'(if4.out_data), 64'(held_data));
      chk("bp hold valid", 64'(if4.out_valid), 64'd1);
      chk("bp in_ready low", 64'(if4.in_ready), 64'd0);
    end
    if4.in_valid = 1'b0;
    take4("bp");
    chk("bp idle state", 64'(dbg4), 64'(IDLE));
    repeat (3) @(negedge clk);
    chk("bp nothing queued", 64'(if4.out_valid), 64'd0);

    // out_ready while idle does nothing
    if4.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle out_ready valid", 64'(if4.out_valid), 64'd0);
    chk("idle out_ready ready", 64'(if4.in_ready), 64'd1);
    if4.out_ready = 1'b0;

    // 7. reset mid-CONV aborts the word
    send4(16'h9999, MODE_BCD2EX3, "abort");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 64'(if4.out_valid), 64'd0);
    chk("abort out_data", 64'(if4.out_data), 64'd0);
    chk("abort in_ready", 64'(if4.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort no valid", 64'(if4.out_valid), 64'd0);
    end
    run4(16'h0000, MODE_BCD2EX3, 16'h3333, 4'b0000, "after abort");

    // DIGITS=1: one conversion cycle
    for (int t = 0; t < 2; t++) begin
      int n = 0;
      while (!if1.in_ready && n < 20) begin @(negedge clk); n++; end
      if1.in_valid = 1'b1;
      if1.in_data  = (t == 0) ? 4'h7 : 4'hE;
      if1.in_mode  = (t == 0) ? MODE_BCD2EX3 : MODE_EX32BCD;
      @(posedge clk);
      @(negedge clk);
      if1.in_valid = 1'b0;
      n = 0;
      while (!if1.out_valid && n < 20) begin @(negedge clk); n++; end
      chk("d1 latency", 64'(n), 64'd1);
      chk("d1 data", 64'(if1.out_data), (t == 0) ? 64'hA : 64'h0);
      chk("d1 err", 64'(if1.out_err), (t == 0) ? 64'd0 : 64'd1);
      if1.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if1.out_ready = 1'b0;
      chk("d1 done", 64'(if1.out_valid), 64'd0);
    end

    // random words against the reference model, random consumer stalls
    for (int w = 0; w < 40; w++) begin
      rdata = 16'($urandom);
      rmode = 1'($urandom_range(0, 1));
      ref_model(rdata, rmode, rres, rmask);
      exp_q.push_back({rmask, rres});
      send4(rdata, rmode, "rand");
      wait_out4("rand", lat);
      chk("rand latency", 64'(lat), 64'd4);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      exp = exp_q.pop_front();
      rd = if4.out_data;
      chk("rand data", 64'(rd), 64'(exp[15:0]));
      chk("rand mask", 64'(if4.out_err_mask), 64'(exp[19:16]));
      chk("rand err", 64'(if4.out_err), 64'(|exp[19:16]));
      take4("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
